// File: rtl/pipe_stage_pkg.sv
`default_nettype none
// ============================================================================
// pipe_stage_pkg : shared types/constants for the elastic pipeline stage
// Rev 1.0
// ============================================================================
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam int OCC_W = 2;

    // Fill bit replicated to build the default reset payload of any width
    localparam logic c_RESET_FILL = 1'b0;

endpackage
`default_nettype wire

// File: rtl/pipe_slot_reg.sv
`default_nettype none
// ============================================================================
// pipe_slot_reg : payload register with load, sync clear-to-reset, async rst
// Rev 1.0
// ============================================================================
module pipe_slot_reg
    import pipe_stage_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{c_RESET_FILL}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (i_clear) begin
            r_q <= RESET_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// pipe_stage_elastic : valid/ready pipeline register with flush.
// Define PIPE_STAGE_SKID_EN for a two-slot skid variant with registered in_ready.
// Rev 1.0
// ============================================================================
module pipe_stage_elastic
    import pipe_stage_pkg::*;
#(
    parameter int               WIDTH             = 32,
    parameter logic [WIDTH-1:0] RESET_VAL         = {WIDTH{c_RESET_FILL}},
    parameter int               FLUSH_CLEARS_DATA = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_clear;
    logic             w_main_load;
    logic [WIDTH-1:0] w_main_d;

    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_clear   = flush && (FLUSH_CLEARS_DATA != 0);
    assign out_valid = (r_state != ST_EMPTY);

`ifdef PIPE_STAGE_SKID_EN
    logic             r_in_ready;
    logic             w_skid_load;
    logic [WIDTH-1:0] w_skid_q;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_push && !w_pop)      w_state_nxt = ST_TWO;
                    else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
                end
                ST_TWO:   if (w_pop) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Main refills from input when it is empty or draining, or from skid in TWO
    assign w_main_load = !flush && ((w_push && ((r_state == ST_EMPTY) || w_pop)) ||
                                    ((r_state == ST_TWO) && w_pop));
    assign w_main_d    = (r_state == ST_TWO) ? w_skid_q : in_data;
    assign w_skid_load = !flush && w_push && (r_state == ST_ONE) && !w_pop;

    // Flush may still swallow an offered beat even when both slots are full
    assign in_ready  = r_in_ready || (flush && !rst);
    assign occupancy = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt != ST_TWO);
        end
    end

    pipe_slot_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_clear),
        .i_d     (in_data),
        .o_q     (w_skid_q)
    );
`else
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
                ST_ONE:   if (w_pop && !w_push) w_state_nxt = ST_EMPTY;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    assign w_main_load = w_push && !flush;
    assign w_main_d    = in_data;
    assign in_ready    = !out_valid || out_ready || flush;
    assign occupancy   = {1'b0, out_valid};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    pipe_slot_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_clear),
        .i_d     (w_main_d),
        .o_q     (out_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_pipe_stage_elastic : directed + scoreboarded checks of pipe_stage_elastic
// Rev 1.0
// ============================================================================
module tb_pipe_stage_elastic;

    localparam int             W     = 32;
    localparam logic [W-1:0]   RST_V = 32'hA5A5_0F0F;
`ifdef PIPE_STAGE_SKID_EN
    localparam int MAX_OCC = 2;
    localparam int RST_RDY = 0;
    localparam int BP_ACC  = 1;
`else
    localparam int MAX_OCC = 1;
    localparam int RST_RDY = 1;
    localparam int BP_ACC  = 0;
`endif

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic         s_acc;
    logic         s_pop;
    logic [W-1:0] s_data;
    logic [W-1:0] q[$];

    pipe_stage_elastic #(
        .WIDTH             (W),
        .RESET_VAL         (RST_V),
        .FLUSH_CLEARS_DATA (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream must hold an offer steady until it is taken
    a_hold: assert property (@(posedge clk) disable iff (rst || flush)
        (in_valid && !in_ready) |=> (in_valid && $stable(in_data)))
        else $error("FAIL upstream_hold: offer changed while stalled");

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample handshakes mid-cycle, then advance to just after the next edge
    task automatic tick();
        @(negedge clk);
        s_acc  = in_valid && in_ready;
        s_pop  = out_valid && out_ready;
        s_data = out_data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt;
        int sent;
        int cyc;
        int model;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        s_acc = 1'b0; s_pop = 1'b0; s_data = '0;
        #1;
        check_val("rst_vld",  out_valid, 0);
        check_val("rst_occ",  occupancy, 0);
        check_val("rst_data", out_data, RST_V);
        check_val("rst_rdy",  in_ready, RST_RDY);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        check_val("rel_rdy", in_ready, 1);

        // Streaming at full rate
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = i;
            tick();
            check_val("stream_acc",  s_acc, 1);
            check_val("stream_vld",  out_valid, 1);
            check_val("stream_data", out_data, i);
        end
        in_valid = 1'b0;
        tick();
        check_val("stream_end", out_valid, 0);

        // Backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678;
        tick();
        in_data = 32'h9ABC_DEF0;
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            acc_cnt += int'(s_acc);
            if (s_acc) in_valid = 1'b0;
            check_val("bp_vld",  out_valid, 1);
            check_val("bp_data", out_data, 32'h1234_5678);
        end
        check_val("bp_acc", acc_cnt, BP_ACC);
        check_val("bp_occ", occupancy, MAX_OCC);
        check_val("bp_rdy", in_ready, 0);
        out_ready = 1'b1;
        tick();
        check_val("bp_rel_vld",  out_valid, 1);
        check_val("bp_rel_data", out_data, 32'h9ABC_DEF0);
        in_valid = 1'b0;
        tick();
        check_val("bp_drain", out_valid, 0);

        // Flush collides with an incoming beat
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
        tick();
        check_val("fl_hold", out_data, 32'h55);
        in_data = 32'hAA; flush = 1'b1;
        tick();
        check_val("fl_acc", s_acc, 1);
        flush = 1'b0; in_valid = 1'b0;
        check_val("fl_vld",  out_valid, 0);
        check_val("fl_occ",  occupancy, 0);
        check_val("fl_data", out_data, RST_V);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("fl_after", out_valid, 0);
        end

        // Asynchronous reset while holding an entry
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        tick();
        in_valid = 1'b0;
        check_val("rm_pre", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check_val("rm_vld",  out_valid, 0);
        check_val("rm_data", out_data, RST_V);
        check_val("rm_occ",  occupancy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        check_val("rm_rdy",  in_ready, 1);
        check_val("rm_vld2", out_valid, 0);

`ifdef PIPE_STAGE_SKID_EN
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
        tick();
        in_data = 32'h2;
        tick();
        in_valid = 1'b0;
        check_val("sk_occ", occupancy, 2);
        check_val("sk_rdy", in_ready, 0);
        check_val("sk_d0",  out_data, 32'h1);
        out_ready = 1'b1;
        tick();
        check_val("sk_d1",   out_data, 32'h2);
        check_val("sk_rdy1", in_ready, 1);
        check_val("sk_occ1", occupancy, 1);
        tick();
        check_val("sk_end", out_valid, 0);
`endif

        // Random traffic against a FIFO scoreboard
        q.delete();
        sent = 0; cyc = 0; model = 0;
        in_valid = 1'b0; s_acc = 1'b0;
        while ((sent < 1000 || model != 0) && cyc < 20000) begin
            if (!(in_valid && !s_acc)) begin
                in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
                in_data  = sent;
            end
            out_ready = ($urandom_range(0, 1) == 1);
            tick();
            cyc++;
            if (s_pop) begin
                check_val("rnd_nonempty", q.size() != 0, 1);
                if (q.size() != 0) check_val("rnd_data", s_data, q.pop_front());
            end
            if (s_acc) begin
                q.push_back(in_data);
                sent++;
            end
            model = model + int'(s_acc) - int'(s_pop);
            check_val("rnd_occ", occupancy, model);
            check_val("rnd_vld", out_valid, model != 0);
        end
        in_valid = 1'b0;
        check_val("rnd_budget", cyc < 20000, 1);
        check_val("rnd_sent",   sent, 1000);
        check_val("rnd_left",   q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
